// File: rtl/marmot_sram_arbiter.sv
// marmot_sram_arbiter
// Shares the 8-bank data-array SRAM between the core RW0 port and a Wishbone
// classic slave. The management SoC uses the slave to preload or inspect memory.
// The core always wins the macros. A Wishbone access waits until the core is
// idle for a cycle. If the core stays busy for TIMEOUT cycles, the access gets an
// error ack instead, and wb_timeout is set.
//
// Optional feature macro: MARMOT_SRAM_ARB_WB_WRITE_EN
//   defined   - Wishbone writes reach the macros (web=0, wmask=wbs_sel_i).
//   undefined - the SRAM is read-only from Wishbone. Writes are acked one cycle
//               after acceptance and never touch the macros.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_*                     Wishbone classic slave (byte address, 32-bit data)
//   core_en/wmode/addr/wdata/wmask, core_rdata
//                             core RW0 port; read data arrives one cycle later
//   ram_csb/web/addr/wdata/wmask, ram_rdata
//                             macro pins (active-low selects, bank k at ram_rdata[32k+:32])
//   wb_timeout                sticky timeout flag, cleared only by reset
module marmot_sram_arbiter #(
    parameter int          ADDR_W    = 12,
    parameter int          BANK_BITS = 3,
    parameter logic [31:0] WB_BASE   = 32'h3000_0000,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF,
    localparam int         NBANK     = 2 ** BANK_BITS,
    localparam int         ROW_W     = ADDR_W - BANK_BITS
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [31:0]           wbs_adr_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    input  logic                  core_en,
    input  logic                  core_wmode,
    input  logic [ADDR_W-1:0]     core_addr,
    input  logic [31:0]           core_wdata,
    input  logic [3:0]            core_wmask,
    output logic [31:0]           core_rdata,
    output logic [NBANK-1:0]      ram_csb,
    output logic                  ram_web,
    output logic [ROW_W-1:0]      ram_addr,
    output logic [31:0]           ram_wdata,
    output logic [3:0]            ram_wmask,
    input  logic [NBANK*32-1:0]   ram_rdata,
    output logic                  wb_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDATA, S_ACK} state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [ADDR_W-1:0]      req_addr_reg;
    logic [BANK_BITS-1:0]   core_bank_reg;
`ifdef MARMOT_SRAM_ARB_WB_WRITE_EN
    logic                   req_we_reg;
    logic [31:0]            req_dat_reg;
    logic [3:0]             req_sel_reg;
`endif

    logic [31:0]            bank_rdata [NBANK];
    logic                   drv_en;
    logic [BANK_BITS-1:0]   drv_bank;
    logic                   wb_hit;
    logic [BANK_BITS-1:0]   req_bank;
    logic                   unused_wb_bits;

    // The window spans exactly the core word space, so the high address bits
    // alone decide whether an access hits.
    assign wb_hit   = (wbs_adr_i[31:ADDR_W+2] == WB_BASE[31:ADDR_W+2]);
    assign req_bank = req_addr_reg[ADDR_W-1:ROW_W];

`ifdef MARMOT_SRAM_ARB_WB_WRITE_EN
    assign unused_wb_bits = ^wbs_adr_i[1:0];
`else
    assign unused_wb_bits = ^{wbs_adr_i[1:0], wbs_sel_i, wbs_dat_i};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_bank
            assign bank_rdata[gi] = ram_rdata[gi*32 +: 32];
            assign ram_csb[gi]    = ~(drv_en && (drv_bank == BANK_BITS'(gi)));
        end
    endgenerate

    // The core read mux uses the bank registered at the read, so it follows the
    // macro's one-cycle output latency.
    assign core_rdata = bank_rdata[core_bank_reg];

    // The macro drive is combinational so that the core reaches the macros with no
    // extra latency. WAIT with the core idle is the Wishbone issue cycle.
    always_comb begin
        drv_en    = 1'b0;
        drv_bank  = '0;
        ram_web   = 1'b1;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        if (core_en) begin
            drv_en    = 1'b1;
            drv_bank  = core_addr[ADDR_W-1:ROW_W];
            ram_web   = ~core_wmode;
            ram_addr  = core_addr[ROW_W-1:0];
            ram_wdata = core_wdata;
            ram_wmask = core_wmask;
        end else if (state_reg == S_WAIT) begin
            drv_en    = 1'b1;
            drv_bank  = req_bank;
            ram_addr  = req_addr_reg[ROW_W-1:0];
`ifdef MARMOT_SRAM_ARB_WB_WRITE_EN
            ram_web   = ~req_we_reg;
            ram_wdata = req_dat_reg;
            ram_wmask = req_we_reg ? req_sel_reg : 4'h0;
`endif
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            req_addr_reg  <= '0;
            core_bank_reg <= '0;
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            wb_timeout    <= 1'b0;
`ifdef MARMOT_SRAM_ARB_WB_WRITE_EN
            req_we_reg    <= 1'b0;
            req_dat_reg   <= '0;
            req_sel_reg   <= '0;
`endif
        end else begin
            if (core_en && !core_wmode) begin
                core_bank_reg <= core_addr[ADDR_W-1:ROW_W];
            end

            case (state_reg)
                S_IDLE: begin
                    if (wbs_stb_i && wbs_cyc_i && !wbs_ack_o) begin
                        // Latch the request now. Changes the master makes
                        // later do not affect this access.
                        req_addr_reg <= wbs_adr_i[ADDR_W+1:2];
`ifdef MARMOT_SRAM_ARB_WB_WRITE_EN
                        req_we_reg   <= wbs_we_i;
                        req_dat_reg  <= wbs_dat_i;
                        req_sel_reg  <= wbs_sel_i;
                        if (!wb_hit) begin
`else
                        if (!wb_hit || wbs_we_i) begin
`endif
                            state_reg <= S_ACK;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= '0;
                        end else begin
                            state_reg <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (!core_en) begin
`ifdef MARMOT_SRAM_ARB_WB_WRITE_EN
                        if (req_we_reg) begin
                            state_reg <= S_ACK;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= '0;
                        end else begin
                            state_reg <= S_RDATA;
                        end
`else
                        state_reg <= S_RDATA;
`endif
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th cycle the core has blocked the access.
                        state_reg  <= S_ACK;
                        wbs_ack_o  <= 1'b1;
                        wb_timeout <= 1'b1;
`ifdef MARMOT_SRAM_ARB_WB_WRITE_EN
                        wbs_dat_o  <= req_we_reg ? 32'h0 : ERR_DATA;
`else
                        wbs_dat_o  <= ERR_DATA;
`endif
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_RDATA: begin
                    state_reg <= S_ACK;
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= bank_rdata[req_bank];
                end

                S_ACK: begin
                    state_reg <= S_IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                    cnt_reg   <= '0;
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_marmot_sram_arbiter.sv
// Directed bench for marmot_sram_arbiter. It uses a behavioural 8-bank SRAM model,
// table-driven Wishbone vectors with the core idle, and hand-written sequences for
// contention, timeout and asynchronous reset.
module tb_marmot_sram_arbiter;

`ifdef MARMOT_SRAM_ARB_WB_WRITE_EN
    localparam bit WR_ON  = 1'b1;
    localparam int WR_LAT = 2;
`else
    localparam bit WR_ON  = 1'b0;
    localparam int WR_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]   wbs_sel_i;
    logic [31:0]  wbs_dat_i, wbs_adr_i;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic         core_en, core_wmode;
    logic [11:0]  core_addr;
    logic [31:0]  core_wdata;
    logic [3:0]   core_wmask;
    logic [31:0]  core_rdata;
    logic [7:0]   ram_csb;
    logic         ram_web;
    logic [8:0]   ram_addr;
    logic [31:0]  ram_wdata;
    logic [3:0]   ram_wmask;
    logic [255:0] ram_rdata;
    logic         wb_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    marmot_sram_arbiter dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .core_en    (core_en),
        .core_wmode (core_wmode),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_wmask (core_wmask),
        .core_rdata (core_rdata),
        .ram_csb    (ram_csb),
        .ram_web    (ram_web),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wmask  (ram_wmask),
        .ram_rdata  (ram_rdata),
        .wb_timeout (wb_timeout)
    );

    // SRAM model: 8 macros of 512 x 32 with byte-masked writes. Read data is
    // registered, so it appears the cycle after the read.
    logic [31:0] mem  [8][512];
    logic [31:0] dout [8];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (!ram_csb[k]) begin
                if (!ram_web) mem[k][ram_addr] <= merge(mem[k][ram_addr], ram_wdata, ram_wmask);
                else          dout[k] <= mem[k][ram_addr];
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_rd
        assign ram_rdata[g*32 +: 32] = dout[g];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic core_wr(input logic [11:0] a, input logic [31:0] d);
        core_en = 1'b1; core_wmode = 1'b1; core_addr = a; core_wdata = d; core_wmask = 4'hF;
        @(posedge clk); #1;
        core_en = 1'b0; core_wmode = 1'b0; core_wmask = 4'h0;
    endtask

    task automatic core_rd(input logic [11:0] a, output logic [31:0] d);
        core_en = 1'b1; core_wmode = 1'b0; core_addr = a;
        @(posedge clk); #1;
        core_en = 1'b0;
        d = core_rdata;
    endtask

    // This task is called one tick after a clock edge. The next edge samples the
    // strobe. lat is the number of edges until ack is seen (the sampling edge counts as 1).
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat, output logic [31:0] rdat,
                           output logic [7:0] csb_seen, output logic web_seen,
                           output logic [31:0] post_ack, output logic [31:0] post_dat);
        lat = 0; rdat = '0; csb_seen = '0; web_seen = 1'b0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            csb_seen = csb_seen | ~ram_csb;
            if (!ram_web) web_seen = 1'b1;
            if (wbs_ack_o) begin
                lat  = k;
                rdat = wbs_dat_o;
                break;
            end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge clk); #1;
        post_ack = {31'h0, wbs_ack_o};
        post_dat = wbs_dat_o;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          lat;
        logic [31:0] rdat;
        logic [7:0]  csb;
        logic        web;
    } vec_t;

    vec_t vecs [11];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          lat;
        logic [31:0] rdat, pa, pd, d;
        logic [7:0]  cs;
        logic        ws;
        int          first_ack, acks, bad_csb;
        logic [31:0] tdat;
        logic [31:0] exp7;

        vecs[0]  = '{1'b0, 32'h3000_28CC, 32'h0,         4'h0, 3, 32'hCAFE_F00D, 8'h20, 1'b0};
        vecs[1]  = '{1'b0, 32'h3000_3FFC, 32'h0,         4'h0, 3, 32'h0BAD_F00D, 8'h80, 1'b0};
        vecs[2]  = '{1'b0, 32'h2000_0000, 32'h0,         4'h0, 1, 32'h0,         8'h00, 1'b0};
        vecs[3]  = '{1'b0, 32'h3000_4000, 32'h0,         4'h0, 1, 32'h0,         8'h00, 1'b0};
        vecs[4]  = '{1'b1, 32'h2FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 1, 32'h0,         8'h00, 1'b0};
        vecs[5]  = '{1'b1, 32'h3000_0404, 32'hA5A5_1234, 4'hF, WR_LAT, 32'h0,
                     WR_ON ? 8'h01 : 8'h00, WR_ON};
        vecs[6]  = '{1'b0, 32'h3000_0404, 32'h0,         4'h0, 3,
                     WR_ON ? 32'hA5A5_1234 : 32'h1111_2222, 8'h01, 1'b0};
        vecs[7]  = '{1'b1, 32'h3000_28CC, 32'hFFFF_FFFF, 4'h0, WR_LAT, 32'h0,
                     WR_ON ? 8'h20 : 8'h00, WR_ON};
        vecs[8]  = '{1'b0, 32'h3000_28CC, 32'h0,         4'h0, 3, 32'hCAFE_F00D, 8'h20, 1'b0};
        vecs[9]  = '{1'b1, 32'h3000_3FFC, 32'h1234_5678, 4'h3, WR_LAT, 32'h0,
                     WR_ON ? 8'h80 : 8'h00, WR_ON};
        vecs[10] = '{1'b0, 32'h3000_3FFC, 32'h0,         4'h0, 3,
                     WR_ON ? 32'h0BAD_5678 : 32'h0BAD_F00D, 8'h80, 1'b0};
        exp7 = WR_ON ? 32'h0BAD_5678 : 32'h0BAD_F00D;

        rst = 1'b1;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_dat_i = 0; wbs_adr_i = 0;
        core_en = 0; core_wmode = 0; core_addr = 0; core_wdata = 0; core_wmask = 0;
        for (int k = 0; k < 8; k++) dout[k] = '0;

        // Check the outputs while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_csb", {24'h0, ram_csb}, 32'hFF);
        chk("rst_web", {31'h0, ram_web}, 32'h1);
        chk("rst_wmask", {28'h0, ram_wmask}, 32'h0);
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_timeout", {31'h0, wb_timeout}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Preload the memory through the core port and read it back through the core port.
        core_wr(12'h101, 32'h1111_2222);
        core_wr(12'hA33, 32'hCAFE_F00D);
        core_wr(12'hFFF, 32'h0BAD_F00D);
        core_rd(12'h101, d); chk("core_rd_b0", d, 32'h1111_2222);
        core_rd(12'hA33, d); chk("core_rd_b5", d, 32'hCAFE_F00D);
        core_rd(12'hFFF, d); chk("core_rd_b7", d, 32'h0BAD_F00D);

        // Wishbone vectors with the core idle.
        for (int i = 0; i < 11; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, lat, rdat, cs, ws, pa, pd);
            $display("vec %0d we=%0d adr=%h sel=%h lat=%0d dat=%h csb_seen=%h web_seen=%0d",
                     i, vecs[i].we, vecs[i].adr, vecs[i].sel, lat, rdat, cs, ws);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_dat", i), rdat, vecs[i].rdat);
            chk($sformatf("vec%0d_csb", i), {24'h0, cs}, {24'h0, vecs[i].csb});
            chk($sformatf("vec%0d_web", i), {31'h0, ws}, {31'h0, vecs[i].web});
            chk($sformatf("vec%0d_ack1", i), pa, 32'h0);
            chk($sformatf("vec%0d_dat0", i), pd, 32'h0);
        end

        // Contention: the core reads bank 5 for 10 cycles while a bank-7 read waits.
        // The master drops strobe and changes the address after acceptance.
        core_en = 1'b1; core_wmode = 1'b0; core_addr = 12'hA33;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_3FFC;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_adr_i = 32'h3000_0404;
            end
            chk($sformatf("cont_csb_c%0d", c), {24'h0, ram_csb}, 32'hDF);
            chk($sformatf("cont_rdata_c%0d", c), core_rdata, 32'hCAFE_F00D);
            chk($sformatf("cont_noack_c%0d", c), {31'h0, wbs_ack_o}, 32'h0);
            if (c == 10) core_en = 1'b0;
        end
        #1;
        chk("cont_issue_csb", {24'h0, ram_csb}, 32'h7F);
        chk("cont_issue_web", {31'h0, ram_web}, 32'h1);
        chk("cont_issue_addr", {23'h0, ram_addr}, 32'h1FF);
        @(posedge clk); #1;
        chk("cont_rdata_cycle_ack", {31'h0, wbs_ack_o}, 32'h0);
        @(posedge clk); #1;
        chk("cont_ack", {31'h0, wbs_ack_o}, 32'h1);
        chk("cont_ack_dat", wbs_dat_o, exp7);
        chk("cont_core_rdata_end", core_rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;
        chk("cont_ack_single", {31'h0, wbs_ack_o}, 32'h0);
        $display("contention read done dat=%h", exp7);

        // Timeout: the core holds bank 3 for 300 cycles while a Wishbone read waits.
        core_en = 1'b1; core_wmode = 1'b0; core_addr = 12'h600;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0404;
        first_ack = -1; acks = 0; bad_csb = 0; tdat = '0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; end
            if (ram_csb != 8'hF7) bad_csb++;
            if (wbs_ack_o) begin
                acks++;
                if (first_ack < 0) begin first_ack = k; tdat = wbs_dat_o; end
            end
            if (k == 254) chk("to_flag_before", {31'h0, wb_timeout}, 32'h0);
        end
        core_en = 1'b0;
        chk("to_ack_cycle", 32'(first_ack), 32'd255);
        chk("to_ack_dat", tdat, 32'hDEAD_BEEF);
        chk("to_ack_count", 32'(acks), 32'd1);
        chk("to_core_owns_csb", 32'(bad_csb), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("to_flag_sticky", {31'h0, wb_timeout}, 32'h1);
        chk("to_no_late_ack", {31'h0, wbs_ack_o}, 32'h0);
        $display("timeout read done ack_cycle=%0d dat=%h", first_ack, tdat);

        // Reset mid-operation: a bank-5 read is pending behind the core, and reset hits mid-cycle.
        core_en = 1'b1; core_wmode = 1'b0; core_addr = 12'h600;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_28CC;
        @(posedge clk); #1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(posedge clk); #3;
        core_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_csb", {24'h0, ram_csb}, 32'hFF);
        chk("mid_rst_web", {31'h0, ram_web}, 32'h1);
        chk("mid_rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("mid_rst_timeout", {31'h0, wb_timeout}, 32'h0);
        #2;
        rst = 1'b0;
        acks = 0; bad_csb = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) acks++;
            if (ram_csb != 8'hFF) bad_csb++;
        end
        chk("mid_rst_no_ack", 32'(acks), 32'd0);
        chk("mid_rst_idle_csb", 32'(bad_csb), 32'd0);
        $display("mid-operation reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/marmot_sram_arbiter.md
Name: marmot_sram_arbiter

Overview:
- Shares the 8-bank data-array SRAM (8 × 512 × 32-bit macros) between the core's RW0 port and the Wishbone slave port, so the management SoC can preload or inspect memory.
- The core has absolute priority. A Wishbone access is issued only on a cycle where the core is not accessing, with a bounded wait (timeout).
- Sits between MarmotCaravelChip's data_arrays_0_ext RW0 port and the macro pins.

Parameters:
- ADDR_W, 12, core word-address width (bank index + row)
- BANK_BITS, 3, bank-select bits; NBANK = 2**BANK_BITS
- WB_BASE, 32'h3000_0000, Wishbone window base, byte address
- TIMEOUT, 255, maximum cycles a Wishbone request waits before an error ack
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- wb_clk_i  in  1  single clock; the macros are clocked from it externally
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle, write enable
- wbs_sel_i  in  4  byte selects
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid only while wbs_ack_o is high, else 0
- core_en, core_wmode  in  1 each  RW0 enable, write mode
- core_addr  in  ADDR_W  word address; [ADDR_W-1:ADDR_W-BANK_BITS] selects the bank
- core_wdata  in  32, core_wmask  in  4  write data, byte mask
- core_rdata  out  32  read data, valid the cycle after a core read
- ram_csb  out  NBANK  active-low chip selects
- ram_web  out  1  active-low write enable
- ram_addr  out  ADDR_W-BANK_BITS  row address
- ram_wdata  out  32, ram_wmask  out  4  to the macros
- ram_rdata  in  NBANK*32  macro read data, bank k at [32k+31:32k]
- wb_timeout  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset values (async): FSM=IDLE, wait counter 0, wbs_ack_o=0, wbs_dat_o=0, wb_timeout=0, bank-select registers 0.
- In reset, with core_en=0, all outputs are idle: ram_csb all 1, ram_web=1, ram_wmask=0.
- Macro drive is combinational:
  - core_en=1: the core drives the macros; csb[bank]=0, web=~core_wmode, addr/wdata/wmask from core.
  - Else, in state ISSUE: Wishbone fields drive the macros.
  - Else: idle.
- Core read: register bank index when core_en & ~core_wmode. Next cycle, core_rdata = ram_rdata[bank_q].
- Wishbone hit: wbs_adr_i[31:ADDR_W+2] == WB_BASE[31:ADDR_W+2]. Word address = wbs_adr_i[ADDR_W+1:2].
- FSM states:
  - IDLE: on stb&cyc&~ack, a hit → WAIT; a miss → ACK with data 0 and no RAM access.
  - WAIT: if core_en=0, issue this cycle (the state is combinationally ISSUE-equivalent: macros driven from the latched Wishbone request), then → RDATA for a read, or → ACK for a write. If core_en=1, count++. When count reaches TIMEOUT, → ACK with ERR_DATA (reads) and set wb_timeout.
  - RDATA: capture ram_rdata[bank of request] into the data register → ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle, wbs_dat_o=data register → IDLE; count cleared.
- Latency with an idle core: read ack 3 cycles after strobe sampled (WAIT, RDATA, ACK); write ack 2 cycles.
- Wishbone request fields (adr, dat, sel, we) are latched in IDLE on acceptance. Changes to the master inputs while the access is pending are ignored.
- Simultaneous core_en and Wishbone issue: the core always wins; the Wishbone request stays in WAIT.
- Wishbone write with wbs_sel_i=0: access issued with wmask=0, still acked.
- stb dropped before ack: the latched request completes and acks once; the ack is ignored by the master.
- Reset mid-operation: the pending access is abandoned, no ack, csb released immediately.

Optional Feature:
- Macro: MARMOT_SRAM_ARB_WB_WRITE_EN.
- Defined: Wishbone writes go through the WAIT/issue path with ram_web=0 and wmask=wbs_sel_i.
- Undefined: the SRAM is read-only from Wishbone. Writes skip WAIT, never assert ram_web=0 or csb, and ack 1 cycle after acceptance; reads are unchanged.

Test Plan:
- Reset: assert wb_rst_i asynchronously mid-cycle → ram_csb=8'hFF, ram_web=1, wbs_ack_o=0, wb_timeout=0 immediately.
- WB write then read, core idle: write 0x3000_0404 data 0xA5A5_1234 sel=4'hF → bank0 row 0x101 written, ack 2 cycles later. Read the same address → wbs_dat_o=0xA5A5_1234, ack 3 cycles after strobe.
- Contention: core_en=1 for 10 cycles while a WB read is pending → core owns ram_csb all 10 cycles. WB issues on cycle 11 and acks 2 cycles later; core_rdata stays correct throughout.
- Timeout: core_en held high for 300 cycles, WB read pending → ack after TIMEOUT=255 wait cycles with 0xDEAD_BEEF, wb_timeout=1 until reset.
- Miss: WB read at 0x2000_0000 → ack next cycle, data 0, ram_csb stays 8'hFF.
- Write disabled (macro undefined): WB write to 0x3000_0000 → ack 1 cycle after acceptance, ram_web never 0; a following read returns the old contents.
